// File: rtl/watermark_fifo.sv
// watermark_fifo: single-clock FWFT FIFO with level, thresholds, sticky errors and flush
//
// Any DEPTH >= 2 is supported; DEPTH does not have to be a power of two.
// Define WATERMARK_FIFO_PEAK_LEVEL_EN to add peak (high-watermark) tracking.
//
// Ports:
//   clock                  rising-edge clock for all state
//   resetn                 asynchronous active-low reset (storage is not reset)
//   write_enable/data      push write_data; the push is ignored while full
//   read_enable            pop the head entry; the pop is ignored while empty
//   read_data              head entry, first-word fall-through (undefined while empty)
//   full/empty/level       occupancy as registered at the last edge
//   flush                  empties the FIFO next cycle; same-cycle push/pop discarded silently
//   lower/upper_threshold  live thresholds, compared unsigned against level
//   overflow/underflow     sticky error flags, cleared by clear_errors (a new error wins)
//   clear_errors           clears overflow/underflow
//   clear_peak, peak_level only with WATERMARK_FIFO_PEAK_LEVEL_EN
module watermark_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               write_enable,
    input  logic [WIDTH-1:0]   write_data,
    output logic               full,
    input  logic               read_enable,
    output logic [WIDTH-1:0]   read_data,
    output logic               empty,
    output logic [LEVEL_W-1:0] level,
    input  logic               flush,
    input  logic [LEVEL_W-1:0] lower_threshold_level,
    output logic               lower_threshold_status,
    input  logic [LEVEL_W-1:0] upper_threshold_level,
    output logic               upper_threshold_status,
    output logic               overflow,
    output logic               underflow,
    input  logic               clear_errors
`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
    ,
    input  logic               clear_peak,
    output logic [LEVEL_W-1:0] peak_level
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               overflow_q, overflow_d, underflow_q, underflow_d;
    logic               wr_acc, rd_acc;

    assign full  = level_q == LEVEL_FULL;
    assign empty = level_q == '0;
    assign level = level_q;
    assign read_data = mem[rd_ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign lower_threshold_status = level_q <= lower_threshold_level;
    assign upper_threshold_status = level_q >= upper_threshold_level;

    // Flush suppresses both transfers and any error they would have raised.
    assign wr_acc = write_enable && !full && !flush;
    assign rd_acc = read_enable && !empty && !flush;

    always_comb begin
        wr_ptr_d = flush ? '0 : !wr_acc ? wr_ptr_q : (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = flush ? '0 : !rd_acc ? rd_ptr_q : (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        level_d  = flush ? '0 :
                   (wr_acc && !rd_acc) ? level_q + LEVEL_W'(1) :
                   (rd_acc && !wr_acc) ? level_q - LEVEL_W'(1) : level_q;
        // Set has priority over clear_errors.
        overflow_d  = (overflow_q && !clear_errors) || (write_enable && full && !flush);
        underflow_d = (underflow_q && !clear_errors) || (read_enable && empty && !flush);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr_q] <= write_data;
    end

`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
    logic [LEVEL_W-1:0] peak_q, peak_d;

    assign peak_level = peak_q;

    // Tracks the next level so a flush with clear_peak yields 0.
    always_comb peak_d = clear_peak ? level_d : (level_d > peak_q) ? level_d : peak_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) peak_q <= '0;
        else peak_q <= peak_d;
    end
`endif
endmodule

// File: tb/tb_watermark_fifo.sv
// tb_watermark_fifo: scoreboard bench for watermark_fifo at DEPTH=5
module tb_watermark_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int LW = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             write_enable = 1'b0;
    logic [WIDTH-1:0] write_data = '0;
    logic             read_enable = 1'b0;
    logic             flush = 1'b0;
    logic             clear_errors = 1'b0;
    logic [LW-1:0]    lower_threshold_level = '0;
    logic [LW-1:0]    upper_threshold_level = '0;
    logic             full, empty, lower_threshold_status, upper_threshold_status, overflow, underflow;
    logic [WIDTH-1:0] read_data;
    logic [LW-1:0]    level;
`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
    logic             clear_peak = 1'b0;
    logic [LW-1:0]    peak_level;
`endif

    int n_chk = 0;
    int n_pass = 0;
    logic [WIDTH-1:0] q[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    int m_peak = 0;

    watermark_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .resetn(resetn),
        .write_enable(write_enable),
        .write_data(write_data),
        .full(full),
        .read_enable(read_enable),
        .read_data(read_data),
        .empty(empty),
        .level(level),
        .flush(flush),
        .lower_threshold_level(lower_threshold_level),
        .lower_threshold_status(lower_threshold_status),
        .upper_threshold_level(upper_threshold_level),
        .upper_threshold_status(upper_threshold_status),
        .overflow(overflow),
        .underflow(underflow),
        .clear_errors(clear_errors)
`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
        ,
        .clear_peak(clear_peak),
        .peak_level(peak_level)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Called at the falling edge: drive inputs, check outputs against the model, advance one cycle.
    task automatic cyc(input bit we, input logic [WIDTH-1:0] wd, input bit re,
                       input bit fl = 0, input bit ce = 0, input bit cp = 0);
        bit m_full, m_empty;
        int n;
        write_enable = we;
        write_data = wd;
        read_enable = re;
        flush = fl;
        clear_errors = ce;
`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
        clear_peak = cp;
`endif
        #1;
        m_full = q.size() == DEPTH;
        m_empty = q.size() == 0;
        check("empty", empty, m_empty);
        check("full", full, m_full);
        check("level", level, q.size());
        check("lower_status", lower_threshold_status, q.size() <= int'(lower_threshold_level));
        check("upper_status", upper_threshold_status, q.size() >= int'(upper_threshold_level));
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
        if (!m_empty) check("read_data", read_data, q[0]);
`ifdef WATERMARK_FIFO_PEAK_LEVEL_EN
        check("peak_level", peak_level, m_peak);
`endif
        m_ovf = (m_ovf && !ce) || (we && m_full && !fl);
        m_unf = (m_unf && !ce) || (re && m_empty && !fl);
        if (fl) q.delete();
        else begin
            if (re && !m_empty) void'(q.pop_front());
            if (we && !m_full) q.push_back(wd);
        end
        n = q.size();
        m_peak = cp ? n : (n > m_peak ? n : m_peak);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        resetn = 1'b1;
        upper_threshold_level = 3'd7;
        @(negedge clock);

        // Fill/drain three times to cross the non-power-of-two pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) cyc(1, 8'(r * 16 + i + 1), 0);
            check("t1_full", full, 1);
            check("t1_level", level, DEPTH);
            for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);
            check("t1_empty", empty, 1);
        end

        // Full with simultaneous write+read.
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hA0 + i), 0);
        cyc(1, 8'hEE, 1);
        check("t2_level", level, 4);
        check("t2_overflow", overflow, 1);
        cyc(0, 0, 0, 0, 1);
        check("t2_cleared", overflow, 0);

        // Underflow from an empty read, then write+read on empty.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("t3_underflow", underflow, 1);
        check("t3_level0", level, 0);
        cyc(1, 8'h5A, 1);
        check("t3_level1", level, 1);
        check("t3_underflow_held", underflow, 1);
        cyc(0, 0, 0, 0, 1);

        // Flush with a same-cycle write discards it without raising errors.
        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 1, 1);
        check("t4_level", level, 0);
        check("t4_empty", empty, 1);
        check("t4_no_ovf", overflow, 0);
        check("t4_no_unf", underflow, 0);
        cyc(1, 8'h77, 0);
        check("t4_readback", read_data, 8'h77);
        cyc(0, 0, 1);

        // Threshold sweep; thresholds move mid-run and statuses follow in the same cycle.
        lower_threshold_level = 3'd1;
        upper_threshold_level = 3'd4;
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
        cyc(0, 0, 0);
        lower_threshold_level = 3'd5;
        upper_threshold_level = 3'd6;
        #1;
        check("t5_lower_live", lower_threshold_status, 1);
        check("t5_upper_live", upper_threshold_status, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);

        // Random traffic with periodic threshold changes.
        for (int i = 0; i < 500; i++) begin
            if (i % 25 == 0) begin
                lower_threshold_level = LW'($urandom_range(0, 7));
                upper_threshold_level = LW'($urandom_range(0, 7));
            end
            cyc($urandom_range(0, 1) == 1, WIDTH'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end
        cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
